// File: rtl/fifo_wr_packer.sv
// rtl/fifo_wr_packer.sv - packs narrow input beats into wide FIFO words with keep mask and last flag
module fifo_wr_packer #(
  parameter  int ISIZE = 8,
  parameter  int RATIO = 4,
  localparam int OSIZE = ISIZE * RATIO,
  localparam int CSIZE = $clog2(RATIO)
) (
  input  logic                     wr_clk,
  input  logic                     rst_n,
  input  logic [ISIZE-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [OSIZE+RATIO:0]     fifo_wdata,
  output logic                     fifo_wr_en,
  input  logic                     fifo_full,
  output logic [15:0]              word_cnt,
  output logic [15:0]              pkt_cnt
);

  localparam logic [CSIZE-1:0] LAST_LANE = CSIZE'(RATIO - 1);

  logic [OSIZE-1:0] acc_q, acc_d;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d;
  logic [CSIZE-1:0] cnt_q, cnt_d;

  logic [OSIZE-1:0] hold_data_q, hold_data_d;
  logic [RATIO-1:0] hold_keep_q, hold_keep_d;
  logic             hold_last_q, hold_last_d;
  logic             hold_vld_q, hold_vld_d;

  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;

  logic             drain;
  logic             accept;
  logic             complete;
  logic [OSIZE-1:0] merged_data;
  logic [RATIO-1:0] merged_keep;

  // Handshake: the hold register empties on a drain, so a beat can be taken in that same cycle.
  always_comb begin
    drain    = hold_vld_q && !fifo_full;
    in_ready = !hold_vld_q || drain;
    accept   = in_valid && in_ready;
    complete = accept && ((cnt_q == LAST_LANE) || in_last);
  end

  // Merge the incoming beat into its lane of the accumulator (lane 0 is the first beat).
  always_comb begin
    merged_data = acc_q;
    merged_keep = acc_keep_q;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CSIZE'(i)) begin
        merged_data[i*ISIZE +: ISIZE] = in_data;
        merged_keep[i]                = 1'b1;
      end
    end
  end

  // Next-state for accumulator, hold register and counters.
  always_comb begin
    acc_d       = acc_q;
    acc_keep_d  = acc_keep_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    hold_last_d = hold_last_q;
    hold_vld_d  = hold_vld_q;
    word_cnt_d  = word_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (complete) begin
      hold_data_d = merged_data;
      hold_keep_d = merged_keep;
      hold_last_d = in_last;
      hold_vld_d  = 1'b1;
      acc_d       = '0;
      acc_keep_d  = '0;
      cnt_d       = '0;
    end else begin
      if (accept) begin
        acc_d      = merged_data;
        acc_keep_d = merged_keep;
        cnt_d      = cnt_q + CSIZE'(1);
      end
      if (drain) begin
        hold_vld_d = 1'b0;
      end
    end

    if (drain) begin
      word_cnt_d = word_cnt_q + 16'd1;
      if (hold_last_q) begin
        pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
    end
  end

  // State registers; reset drops any partial word and any pending hold word.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_keep_q  <= '0;
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      hold_last_q <= 1'b0;
      hold_vld_q  <= 1'b0;
      word_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      acc_keep_q  <= acc_keep_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      hold_last_q <= hold_last_d;
      hold_vld_q  <= hold_vld_d;
      word_cnt_q  <= word_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  // FIFO side: the write strobe is the drain condition, so a full FIFO is never written.
  always_comb begin
    fifo_wr_en = drain;
    fifo_wdata = {hold_last_q, hold_keep_q, hold_data_q};
    word_cnt   = word_cnt_q;
    pkt_cnt    = pkt_cnt_q;
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb/tb_fifo_wr_packer.sv - self-checking bench for fifo_wr_packer with a byte-queue reference model
module tb_fifo_wr_packer;

  localparam int ISIZE = 8;
  localparam int RATIO = 4;
  localparam int WW    = ISIZE * RATIO + RATIO + 1;

  logic              wr_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ISIZE-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [WW-1:0]     fifo_wdata;
  logic              fifo_wr_en;
  logic              fifo_full = 1'b0;
  logic [15:0]       word_cnt;
  logic [15:0]       pkt_cnt;

  int checks = 0;
  int errs = 0;

  logic [7:0]    pend_bytes[$];
  logic [WW-1:0] exp_q[$];
  int            total_waits;
  bit            rnd_full = 1'b0;
  logic [WW-1:0] snap;

  fifo_wr_packer #(.ISIZE(ISIZE), .RATIO(RATIO)) dut (
    .wr_clk     (wr_clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .fifo_wdata (fifo_wdata),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .word_cnt   (word_cnt),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: collect accepted bytes; a word is formed when RATIO bytes are gathered or last is seen.
  task automatic model_beat(input logic [7:0] d, input logic l);
    logic [WW-1:0] w;
    pend_bytes.push_back(d);
    if (l || pend_bytes.size() == RATIO) begin
      w = '0;
      foreach (pend_bytes[i]) begin
        w[i*ISIZE +: ISIZE]  = pend_bytes[i];
        w[ISIZE*RATIO + i]   = 1'b1;
      end
      w[WW-1] = l;
      exp_q.push_back(w);
      pend_bytes.delete();
    end
  endtask

  task automatic rand_full_step();
    if (rnd_full) fifo_full = ($urandom_range(0, 3) == 0);
  endtask

  // Present one beat, wait (bounded) for acceptance, then release valid just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    int waits;
    bit ok;
    waits = 0;
    ok = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!ok && waits < 1000) begin
      @(negedge wr_clk);
      if (in_ready) ok = 1'b1;
      else begin
        @(posedge wr_clk);
        #1;
        rand_full_step();
        waits++;
      end
    end
    if (!ok) chk("accept_timeout", 64'(waits), 64'd0);
    @(posedge wr_clk);
    model_beat(d, l);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rand_full_step();
    total_waits += waits;
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  // Scoreboard: every FIFO write must match the next expected word and never happen while full.
  always @(negedge wr_clk) begin
    if (rst_n && fifo_wr_en) begin
      chk("wr_while_full", 64'(fifo_full), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(fifo_wdata), 64'hDEAD_BEEF_DEAD);
      end else begin
        chk("word", 64'(fifo_wdata), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    total_waits = 0;

    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_wdata", 64'(fifo_wdata), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    @(negedge wr_clk);
    rst_n = 1'b1;
    tick();

    // Full word, continuous valid; write appears the cycle after the last beat
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    @(negedge wr_clk);
    chk("t1_wr_en", 64'(fifo_wr_en), 64'd1);
    chk("t1_wdata", 64'(fifo_wdata), {27'd0, 1'b1, 4'hF, 32'h44332211});
    tick();
    chk("t1_word_cnt", 64'(word_cnt), 64'd1);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Short packet
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    @(negedge wr_clk);
    chk("t2_wdata", 64'(fifo_wdata), {27'd0, 1'b1, 4'h3, 32'h0000BBAA});
    tick();

    // Backpressure: hold stays put while full, one write on release
    fifo_full = 1'b1;
    send(8'hC0, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b1);
    @(negedge wr_clk);
    chk("t3_wr_en_full", 64'(fifo_wr_en), 64'd0);
    chk("t3_in_ready_full", 64'(in_ready), 64'd0);
    snap = fifo_wdata;
    chk("t3_wdata", 64'(snap), {27'd0, 1'b1, 4'hF, 32'hC3C2C1C0});
    repeat (3) tick();
    @(negedge wr_clk);
    chk("t3_wdata_stable", 64'(fifo_wdata), 64'(snap));
    chk("t3_cnt_stalled", 64'(word_cnt), 64'd2);
    tick();
    fifo_full = 1'b0;
    @(negedge wr_clk);
    chk("t3_wr_en_release", 64'(fifo_wr_en), 64'd1);
    chk("t3_in_ready_release", 64'(in_ready), 64'd1);
    tick();
    @(negedge wr_clk);
    chk("t3_single_write", 64'(fifo_wr_en), 64'd0);
    chk("t3_word_cnt", 64'(word_cnt), 64'd3);
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);
    tick();

    // Streaming 16 beats, never stalled
    total_waits = 0;
    for (int i = 0; i < 16; i++) send(8'(i), (i == 15));
    repeat (2) tick();
    chk("t4_no_stall", 64'(total_waits), 64'd0);
    chk("t4_word_cnt", 64'(word_cnt), 64'd7);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd4);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-word discards the partial accumulator
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    rst_n = 1'b0;
    pend_bytes.delete();
    #1;
    chk("t5_word_cnt_clr", 64'(word_cnt), 64'd0);
    chk("t5_pkt_cnt_clr", 64'(pkt_cnt), 64'd0);
    chk("t5_wr_en_rst", 64'(fifo_wr_en), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (3) begin
        @(negedge wr_clk);
        if (fifo_wr_en) seen++;
      end
      chk("t5_no_write", 64'(seen), 64'd0);
    end
    tick();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    @(negedge wr_clk);
    chk("t5_wdata", 64'(fifo_wdata), {27'd0, 1'b1, 4'hF, 32'h04030201});
    tick();

    // Randomized traffic with random gaps and random FIFO full
    rnd_full = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(8'($urandom), (i == 399) || ($urandom_range(0, 4) == 0));
      repeat ($urandom_range(0, 2)) begin
        tick();
        rand_full_step();
      end
    end
    rnd_full = 1'b0;
    fifo_full = 1'b0;
    repeat (3) tick();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // Counter wrap: 65536 single-beat packets bring both counters back to 0
    rst_n = 1'b0;
    exp_q.delete();
    pend_bytes.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 65536; i++) send(8'($urandom), 1'b1);
    repeat (2) tick();
    chk("wrap_word_cnt", 64'(word_cnt), 64'd0);
    chk("wrap_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
